// File: rtl/tdm_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tdm_voice_mixer
// Purpose  : Time-multiplexed sawtooth voice mixer. Per-voice tuning, gate and
//            velocity state are written from the SPI decoder strobes. Each
//            sample tick starts a sweep that visits one voice per clock.
//            Every active voice adds its velocity-scaled sawtooth to an
//            accumulator and advances its phase. The accumulated sum is
//            shifted, saturated and presented as one signed mixed sample.
// Ports    : i_clk, i_reset         clock, async active-high reset
//            i_sample_tick          strobe that starts a sweep
//            i_SPI_flag_dds         tuning write strobe
//            i_SPI_flag_adsr        gate write strobe (i_SPI_note_status)
//            i_SPI_voice_index      target voice of the SPI strobes
//            i_SPI_tuning_code      phase increment for a dds write
//            i_SPI_velocity         velocity captured on note-on
//            i_SPI_note_status      1 = note-on, 0 = note-off
//            o_mixed_sample         signed saturated mix
//            o_sample_valid         pulse when o_mixed_sample updates
//            o_busy                 sweep in progress (through valid cycle)
//            o_overrun              pulse after a tick that arrived while busy
// Revision : 1.0  initial release
// ============================================================================
module tdm_voice_mixer #(
  parameter int NUM_VOICES  = 256,
  parameter int VOICE_IDX_W = 8,
  parameter int PHASE_W     = 32,
  parameter int SAMPLE_W    = 16,
  parameter int OUT_W       = 24,
  parameter int MIX_SHIFT   = 7
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_sample_tick,
  input  logic                   i_SPI_flag_dds,
  input  logic                   i_SPI_flag_adsr,
  input  logic [VOICE_IDX_W-1:0] i_SPI_voice_index,
  input  logic [PHASE_W-1:0]     i_SPI_tuning_code,
  input  logic [6:0]             i_SPI_velocity,
  input  logic                   i_SPI_note_status,
  output logic [OUT_W-1:0]       o_mixed_sample,
  output logic                   o_sample_valid,
  output logic                   o_busy,
  output logic                   o_overrun
);

  localparam int c_SEL_W  = $clog2(NUM_VOICES);
  localparam int c_PROD_W = SAMPLE_W + 8;
  localparam int c_ACC_W  = SAMPLE_W + 8 + VOICE_IDX_W;
  // One guard bit above the wider of accumulator and output keeps the
  // saturation limits representable as signed constants.
  localparam int c_CMP_W  = ((c_ACC_W > OUT_W) ? c_ACC_W : OUT_W) + 1;

  localparam logic [VOICE_IDX_W:0] c_NUM_VOICES = (VOICE_IDX_W+1)'(NUM_VOICES);
  localparam logic [c_SEL_W-1:0]   c_LAST_VOICE = c_SEL_W'(NUM_VOICES - 1);

  localparam logic signed [c_CMP_W-1:0] c_OUT_MAX =
    {{(c_CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [c_CMP_W-1:0] c_OUT_MIN =
    {{(c_CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWEEP  = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Per-voice storage
  logic [PHASE_W-1:0] r_phase  [NUM_VOICES];
  logic [PHASE_W-1:0] r_tuning [NUM_VOICES];
  logic [6:0]         r_vel    [NUM_VOICES];
  logic               r_active [NUM_VOICES];

  logic [c_SEL_W-1:0]         r_voice;
  logic signed [c_ACC_W-1:0]  r_acc;
  logic [OUT_W-1:0]           r_mixed_sample;
  logic                       r_sample_valid;
  logic                       r_overrun;

  logic                       w_busy;
  logic                       w_tick_accept;
  logic                       w_spi_idx_ok;
  logic [c_SEL_W-1:0]         w_spi_sel;
  logic signed [SAMPLE_W-1:0] w_saw;
  logic signed [c_PROD_W-1:0] w_saw_x;
  logic signed [c_PROD_W-1:0] w_vel_x;
  logic signed [c_PROD_W-1:0] w_prod;
  logic signed [c_ACC_W-1:0]  w_contrib;
  logic signed [c_ACC_W-1:0]  w_shifted;
  logic signed [c_CMP_W-1:0]  w_shifted_x;
  logic [OUT_W-1:0]           w_saturated;

  // The valid cycle still counts as busy, so a tick landing there is an
  // overrun rather than the start of a new sweep.
  assign w_busy        = (r_state != S_IDLE) || r_sample_valid;
  assign w_tick_accept = i_sample_tick && (r_state == S_IDLE) && !r_sample_valid;

  assign w_spi_idx_ok  = ({1'b0, i_SPI_voice_index} < c_NUM_VOICES);
  assign w_spi_sel     = i_SPI_voice_index[c_SEL_W-1:0];

  // Velocity-scaled sawtooth of the voice being visited, using pre-update phase
  assign w_saw     = r_phase[r_voice][PHASE_W-1 -: SAMPLE_W];
  assign w_saw_x   = {{(c_PROD_W-SAMPLE_W){w_saw[SAMPLE_W-1]}}, w_saw};
  assign w_vel_x   = {{(c_PROD_W-7){1'b0}}, r_vel[r_voice]};
  assign w_prod    = w_saw_x * w_vel_x;
  assign w_contrib = r_active[r_voice]
                   ? {{(c_ACC_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod}
                   : '0;

  assign w_shifted   = r_acc >>> MIX_SHIFT;
  assign w_shifted_x = {{(c_CMP_W-c_ACC_W){w_shifted[c_ACC_W-1]}}, w_shifted};

  always_comb begin
    w_saturated = w_shifted_x[OUT_W-1:0];
    if (w_shifted_x > c_OUT_MAX) begin
      w_saturated = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_shifted_x < c_OUT_MIN) begin
      w_saturated = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_tick_accept) w_next_state = S_SWEEP;
      S_SWEEP:  if (r_voice == c_LAST_VOICE) w_next_state = S_OUTPUT;
      S_OUTPUT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Datapath and voice storage. SPI writes come after the sweep update so
  // that a write to the voice being visited wins over its phase advance.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_voice        <= '0;
      r_acc          <= '0;
      r_mixed_sample <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_phase[i]  <= '0;
        r_tuning[i] <= '0;
        r_vel[i]    <= '0;
        r_active[i] <= 1'b0;
      end
    end else begin
      r_sample_valid <= 1'b0;
      r_overrun      <= i_sample_tick && w_busy;

      case (r_state)
        S_IDLE: begin
          if (w_tick_accept) begin
            r_acc   <= '0;
            r_voice <= '0;
          end
        end
        S_SWEEP: begin
          r_acc   <= r_acc + w_contrib;
          r_voice <= r_voice + c_SEL_W'(1);
          if (r_active[r_voice]) begin
            r_phase[r_voice] <= r_phase[r_voice] + r_tuning[r_voice];
          end
        end
        S_OUTPUT: begin
          r_mixed_sample <= w_saturated;
          r_sample_valid <= 1'b1;
        end
        default: ;
      endcase

      if (i_SPI_flag_adsr && w_spi_idx_ok) begin
        if (i_SPI_note_status) begin
          r_active[w_spi_sel] <= 1'b1;
          r_vel[w_spi_sel]    <= i_SPI_velocity;
          r_phase[w_spi_sel]  <= '0;
        end else begin
          r_active[w_spi_sel] <= 1'b0;
        end
      end

      if (i_SPI_flag_dds && w_spi_idx_ok) begin
        r_tuning[w_spi_sel] <= i_SPI_tuning_code;
      end
    end
  end

  assign o_mixed_sample = r_mixed_sample;
  assign o_sample_valid = r_sample_valid;
  assign o_busy         = w_busy;
  assign o_overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_tdm_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_voice_mixer
// Purpose  : Scoreboard bench for tdm_voice_mixer (4 voices, 16-bit output,
//            shift 7). A voice-level model computes each expected mix when a
//            tick is issued; a monitor compares whenever a sample is valid.
// Revision : 1.0  initial release
// ============================================================================
module tb_tdm_voice_mixer;

  localparam int N     = 4;
  localparam int IDX_W = 8;
  localparam int OUT_W = 16;
  localparam int SHIFT = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0;
  logic              dds = 1'b0;
  logic              adsr = 1'b0;
  logic              note = 1'b0;
  logic [IDX_W-1:0]  idx = '0;
  logic [31:0]       code = '0;
  logic [6:0]        vel = '0;
  logic [OUT_W-1:0]  mixed;
  logic              valid;
  logic              busy;
  logic              ovr;

  tdm_voice_mixer #(
    .NUM_VOICES (N),
    .VOICE_IDX_W(IDX_W),
    .PHASE_W    (32),
    .SAMPLE_W   (16),
    .OUT_W      (OUT_W),
    .MIX_SHIFT  (SHIFT)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_sample_tick    (tick),
    .i_SPI_flag_dds   (dds),
    .i_SPI_flag_adsr  (adsr),
    .i_SPI_voice_index(idx),
    .i_SPI_tuning_code(code),
    .i_SPI_velocity   (vel),
    .i_SPI_note_status(note),
    .o_mixed_sample   (mixed),
    .o_sample_valid   (valid),
    .o_busy           (busy),
    .o_overrun        (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit [31:0] m_phase [N];
  bit [31:0] m_tune  [N];
  int        m_vel   [N];
  bit        m_act   [N];
  int        busy_until = -1;
  int        exp_ovr = 0;
  int        seen_ovr = 0;

  typedef struct { int val; int cyc; } exp_t;
  exp_t q[$];

  function automatic int model_sweep();
    longint sum = 0;
    longint s;
    logic signed [15:0] saw;
    for (int v = 0; v < N; v++) begin
      if (m_act[v]) begin
        saw = m_phase[v][31:16];
        sum += longint'(saw) * m_vel[v];
        m_phase[v] = m_phase[v] + m_tune[v];
      end
    end
    s = sum >>> SHIFT;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_phase[v] = '0; m_tune[v] = '0; m_vel[v] = 0; m_act[v] = 1'b0;
    end
    q.delete();
    busy_until = -1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    exp_t e;
    tick = 1'b1;
    if (cyc <= busy_until) begin
      exp_ovr++;
    end else begin
      e.val = model_sweep();
      e.cyc = cyc + N + 2;
      q.push_back(e);
      busy_until = cyc + N + 2;
    end
    step();
    tick = 1'b0;
  endtask

  task automatic spi(input bit d, input bit a, input bit n, input int i,
                     input bit [31:0] c, input int ve);
    dds = d; adsr = a; note = n; idx = IDX_W'(i); code = c; vel = 7'(ve);
    if (i < N) begin
      if (a) begin
        if (n) begin
          m_act[i] = 1'b1; m_vel[i] = ve; m_phase[i] = '0;
        end else begin
          m_act[i] = 1'b0;
        end
      end
      if (d) m_tune[i] = c;
    end
    step();
    dds = 1'b0; adsr = 1'b0; note = 1'b0;
  endtask

  task automatic settle();
    repeat (N + 3) step();
  endtask

  // ---------------- monitor ----------------
  int last = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last = 0;
    end else begin
      if (ovr) seen_ovr++;
      if (valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sample_value", longint'($signed(mixed)), e.val);
          chk("valid_cycle", cyc, e.cyc);
        end
        last = int'($signed(mixed));
      end else begin
        chk("hold_value", longint'($signed(mixed)), last);
      end
    end
  end

  // ---------------- main sequence ----------------
  int bcnt;
  int k;
  int nw;
  int ri;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sample", mixed, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", ovr, 0);
    rst = 1'b0;
    step();

    // Empty sweep: value 0, latency N+2, busy from T+1 through valid
    do_tick();
    bcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("busy_cycles", bcnt, N + 2);

    // Single voice sawtooth, including wrap into the negative half
    spi(1'b1, 1'b1, 1'b1, 1, 32'h1000_0000, 127);
    repeat (10) begin
      do_tick();
      settle();
    end

    // Tick two cycles after a tick: one overrun, one sample
    do_tick();
    step();
    do_tick();
    repeat (N + 4) step();
    chk("overrun_count", seen_ovr, exp_ovr);

    // Note-off then note-on restart
    spi(1'b0, 1'b1, 1'b0, 1, 32'h0, 0);
    do_tick(); settle();
    spi(1'b0, 1'b1, 1'b1, 1, 32'h0, 100);
    repeat (2) begin do_tick(); settle(); end

    // Out-of-range index is ignored
    spi(1'b1, 1'b1, 1'b1, 200, 32'h4000_0000, 127);
    do_tick(); settle();

    // Positive saturation, then small negative value (floor shift)
    for (int v = 0; v < N; v++) spi(1'b1, 1'b1, 1'b1, v, 32'h7FFF_0000, 127);
    repeat (3) begin do_tick(); settle(); end

    // Negative saturation
    for (int v = 0; v < N; v++) spi(1'b1, 1'b1, 1'b1, v, 32'h8000_0000, 127);
    repeat (2) begin do_tick(); settle(); end

    // Same-cycle collisions with the voice being visited
    for (int v = 0; v < N; v++) spi(1'b1, 1'b1, 1'b1, v, 32'h0345_6789 * (v + 1), 40 + v);
    do_tick(); settle();
    do_tick();
    step();
    step();
    spi(1'b1, 1'b1, 1'b1, 2, 32'h0123_4567, 50);
    settle();
    do_tick();
    step();
    spi(1'b1, 1'b0, 1'b0, 1, 32'h2222_0000, 0);
    settle();
    repeat (2) begin do_tick(); settle(); end

    // Reset mid-sweep
    do_tick();
    step();
    rst = 1'b1;
    #1;
    chk("midreset_sample", mixed, 0);
    chk("midreset_valid", valid, 0);
    chk("midreset_busy", busy, 0);
    model_reset();
    step();
    rst = 1'b0;
    step();
    do_tick(); settle();

    // Randomized traffic with occasional overlapping ticks
    for (int it = 0; it < 40; it++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        ri = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(0, N - 1);
        spi(1'($urandom), 1'($urandom), 1'($urandom), ri, $urandom,
            $urandom_range(0, 127));
      end
      do_tick();
      k = $urandom_range(0, N + 3);
      repeat (k) step();
      if ($urandom_range(0, 2) == 0) do_tick();
      settle();
    end

    repeat (N + 4) step();
    chk("pending_expect", q.size(), 0);
    chk("overrun_total", seen_ovr, exp_ovr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
